// File: rtl/mem_access_unit_pkg.sv
// Shared types for the memory access unit: FSM states, error codes, default wait limit.
package mem_access_unit_pkg;

  localparam int DEFAULT_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_CONFLICT = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } mem_err_t;

endpackage

// File: rtl/mem_access_unit_wait_timer.sv
// Counts cycles spent waiting for a memory ack; expire is high in the last allowed wait cycle.
// Cleared whenever the unit is not waiting; saturates at the limit.
module mem_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + CW'(1);
    end
  end

  assign expire = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// Memory access sequencer: latches one read/write in IDLE, holds the request until ack or timeout.
// Latency: MemDone two cycles after launch at best; memory stalls by withholding mem_ack.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int AW      = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          MemRead,
  input  logic          MemWrite,
  input  logic          IorD,
  input  logic          IRWrite,
  input  logic [AW-1:0] PC,
  input  logic [AW-1:0] ULAOut,
  input  logic [AW-1:0] WriteData,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [AW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [AW-1:0] mem_rdata,
  output logic [AW-1:0] IR,
  output logic [AW-1:0] MDR,
  output logic [5:0]    Opcode,
  output logic [5:0]    Funct,
  output logic          MemDone,
  output logic [1:0]    MemErr
);

  state_t        state_q, state_d;
  mem_err_t      err_q, err_code;
  logic [AW-1:0] addr_q, wdata_q, ir_q, mdr_q, sel_addr;
  logic          we_q, ir_load_q;
  logic          start, capture, err_set, expire;

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (state_q != REQ),
    .enable (state_q == REQ),
    .expire (expire)
  );

  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    capture  = 1'b0;
    err_set  = 1'b0;
    err_code = ERR_NONE;
    sel_addr = IorD ? ULAOut : PC;
    case (state_q)
      IDLE: begin
        if (MemRead || MemWrite) begin
          // Misalignment is reported ahead of any other launch decision.
          if (sel_addr[1:0] != 2'b00) begin
            err_set  = 1'b1;
            err_code = ERR_MISALIGN;
            state_d  = ERR;
          end else if (MemRead && MemWrite) begin
            err_set  = 1'b1;
            err_code = ERR_CONFLICT;
            state_d  = ERR;
          end else begin
            start   = 1'b1;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        // An ack arriving in the expiry cycle still completes the access.
        if (mem_ack) begin
          capture = 1'b1;
          state_d = DONE;
        end else if (expire) begin
          err_set  = 1'b1;
          err_code = ERR_TIMEOUT;
          state_d  = ERR;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      err_q     <= ERR_NONE;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      ir_load_q <= 1'b0;
      ir_q      <= '0;
      mdr_q     <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        addr_q    <= sel_addr;
        wdata_q   <= WriteData;
        we_q      <= MemWrite;
        ir_load_q <= IRWrite && MemRead;
      end
      if (capture && !we_q) begin
        mdr_q <= mem_rdata;
        if (ir_load_q) ir_q <= mem_rdata;
      end
      if (err_set) err_q <= err_code;
    end
  end

  assign mem_req   = (state_q == REQ);
  assign mem_we    = mem_req && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign IR        = ir_q;
  assign MDR       = mdr_q;
  assign Opcode    = ir_q[31:26];
  assign Funct     = ir_q[5:0];
  assign MemDone   = (state_q == DONE) || (state_q == ERR);
  assign MemErr    = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus randomized transactions against a transaction-level model.
module tb_mem_access_unit;

  localparam int TO = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        MemRead = 1'b0, MemWrite = 1'b0, IorD = 1'b0, IRWrite = 1'b0;
  logic [31:0] PC = '0, ULAOut = '0, WriteData = '0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] IR, MDR;
  logic [5:0]  Opcode, Funct;
  logic        MemDone;
  logic [1:0]  MemErr;

  int          n_checks = 0;
  int          n_errors = 0;

  // Architectural model: what the registers should hold after each transaction.
  logic [31:0] m_ir = '0, m_mdr = '0;
  logic [1:0]  m_err = '0;

  mem_access_unit #(.TIMEOUT(TO), .AW(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .IorD      (IorD),
    .IRWrite   (IRWrite),
    .PC        (PC),
    .ULAOut    (ULAOut),
    .WriteData (WriteData),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .IR        (IR),
    .MDR       (MDR),
    .Opcode    (Opcode),
    .Funct     (Funct),
    .MemDone   (MemDone),
    .MemErr    (MemErr)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic scramble_strobes();
    MemRead   = 1'($urandom);
    MemWrite  = 1'($urandom);
    IorD      = 1'($urandom);
    IRWrite   = 1'($urandom);
    PC        = $urandom;
    ULAOut    = $urandom;
    WriteData = $urandom;
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_ir"},     IR,            m_ir);
    check({tag, "_mdr"},    MDR,           m_mdr);
    check({tag, "_opcode"}, 32'(Opcode),   32'(m_ir[31:26]));
    check({tag, "_funct"},  32'(Funct),    32'(m_ir[5:0]));
    check({tag, "_err"},    32'(MemErr),   32'(m_err));
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset    = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    mem_ack  = 1'b1;
    @(negedge clock);
    @(negedge clock);
    m_ir = '0; m_mdr = '0; m_err = '0;
    check("rst_req",   32'(mem_req),  0);
    check("rst_we",    32'(mem_we),   0);
    check("rst_addr",  mem_addr,      0);
    check("rst_wdata", mem_wdata,     0);
    check("rst_done",  32'(MemDone),  0);
    check_regs("rst");
    reset   = 1'b1;
    mem_ack = 1'b0;
  endtask

  // One access launched from IDLE; d = number of req cycles before the ack cycle.
  task automatic do_access(input logic r, input logic w, input logic iord, input logic irw,
                           input logic [31:0] pc, input logic [31:0] ula, input logic [31:0] wd,
                           input int d, input logic [31:0] rdata, input string tag);
    logic [31:0] sel;
    int          req_cycles, done_cycle;
    logic        completes;
    @(negedge clock);
    check({tag, "_idle_req"},  32'(mem_req), 0);
    check({tag, "_idle_done"}, 32'(MemDone), 0);
    MemRead = r; MemWrite = w; IorD = iord; IRWrite = irw;
    PC = pc; ULAOut = ula; WriteData = wd;
    mem_ack   = 1'($urandom);
    mem_rdata = $urandom;

    sel = iord ? ula : pc;
    completes = 1'b0;
    if (sel[1:0] != 2'b00) begin
      req_cycles = 0; done_cycle = 1; m_err = 2'd1;
    end else if (r && w) begin
      req_cycles = 0; done_cycle = 1; m_err = 2'd2;
    end else if (d < TO) begin
      req_cycles = d + 1; done_cycle = d + 2; completes = 1'b1;
      if (r) begin
        m_mdr = rdata;
        if (irw) m_ir = rdata;
      end
    end else begin
      req_cycles = TO; done_cycle = TO + 1; m_err = 2'd3;
    end

    for (int c = 1; c <= done_cycle; c++) begin
      @(negedge clock);
      check({tag, "_req"},  32'(mem_req), 32'(c <= req_cycles));
      check({tag, "_done"}, 32'(MemDone), 32'(c == done_cycle));
      if (c <= req_cycles) begin
        check({tag, "_addr"},  mem_addr,     sel);
        check({tag, "_we"},    32'(mem_we),  32'(w));
        check({tag, "_wdata"}, mem_wdata,    wd);
        mem_ack   = completes && (c == req_cycles);
        mem_rdata = (completes && c == req_cycles) ? rdata : $urandom;
      end else begin
        mem_ack   = 1'($urandom);
        mem_rdata = $urandom;
      end
      if (c == done_cycle) check_regs(tag);
      scramble_strobes();
    end
  endtask

  task automatic idle_cycles(input int n);
    @(negedge clock);
    MemRead = 1'b0; MemWrite = 1'b0;
    for (int c = 0; c < n; c++) begin
      mem_ack   = 1'($urandom);
      mem_rdata = $urandom;
      @(negedge clock);
      check("idle_req",  32'(mem_req), 0);
      check("idle_done", 32'(MemDone), 0);
      check_regs("idle");
    end
    mem_ack = 1'b0;
  endtask

  task automatic reset_mid_req();
    @(negedge clock);
    MemRead = 1'b1; MemWrite = 1'b0; IorD = 1'b0; IRWrite = 1'b1;
    PC = {$urandom} & 32'hFFFF_FFFC;
    mem_ack = 1'b0;
    @(negedge clock);
    check("mid_req_up", 32'(mem_req), 1);
    reset = 1'b0;
    MemRead = 1'b0; IRWrite = 1'b0;
    @(negedge clock);
    m_ir = '0; m_mdr = '0; m_err = '0;
    check("mid_req_low", 32'(mem_req), 0);
    reset     = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = $urandom | 32'h1;
    @(negedge clock);
    check("mid_late_req",  32'(mem_req), 0);
    check("mid_late_done", 32'(MemDone), 0);
    check_regs("mid_late");
    mem_ack = 1'b0;
  endtask

  initial begin
    logic        r, w, iord, irw;
    logic [31:0] a_pc, a_ula;
    int          sel, d;

    do_reset();

    do_access(1, 0, 0, 1, 32'h0000_0040, 32'h0, 32'h0, 3, 32'h8C22_0004, "lw_fetch");
    check("lw_fetch_opcode_lit", 32'(Opcode), 32'h23);
    do_access(0, 1, 1, 0, 32'h0, 32'h0000_0100, 32'hDEAD_BEEF, 0, 32'h1234_5678, "sw_fast");
    do_access(1, 0, 1, 0, 32'h0, 32'h0000_0102, 32'h0, 0, 32'h0, "misalign");
    do_access(1, 0, 0, 0, 32'h0000_0200, 32'h0, 32'h0, 2, 32'hCAFE_0001, "after_err");
    do_reset();
    do_access(1, 0, 0, 0, 32'h0000_0300, 32'h0, 32'h0, TO, 32'h0, "timeout");
    do_reset();
    do_access(1, 0, 0, 0, 32'h0000_0304, 32'h0, 32'h0, TO - 1, 32'hA5A5_5A5A, "ack_at_limit");
    do_access(1, 1, 0, 0, 32'h0000_0400, 32'h0, 32'h0, 0, 32'h0, "conflict");
    do_access(1, 0, 0, 1, 32'h0000_0044, 32'h0, 32'h0, 1, 32'h0123_4567, "before_mid");
    reset_mid_req();

    for (int i = 0; i < 80; i++) begin
      sel = $urandom_range(0, 11);
      if (sel == 0) begin
        idle_cycles(2);
      end else if (sel == 1) begin
        reset_mid_req();
      end else begin
        r = 1'b1; w = 1'b0;
        case ($urandom_range(0, 7))
          0:       begin r = 1'b1; w = 1'b1; end
          1, 2, 3: begin r = 1'b0; w = 1'b1; end
          default: begin r = 1'b1; w = 1'b0; end
        endcase
        iord  = 1'($urandom);
        irw   = 1'($urandom);
        a_pc  = $urandom;
        a_ula = $urandom;
        if ((r && w) || $urandom_range(0, 4) != 0) begin
          a_pc[1:0]  = 2'b00;
          a_ula[1:0] = 2'b00;
        end
        d = ($urandom_range(0, 3) == 0) ? $urandom_range(TO - 2, TO + 1) : $urandom_range(0, 5);
        do_access(r, w, iord, irw, a_pc, a_ula, $urandom, d, $urandom, "rand");
        if (m_err != 2'd0) do_reset();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
